// File: rtl/execute_unit.sv
// rtl/execute_unit.sv - execute stage: register file, flags and ALU behind a valid/ready issue port
//
// Optional feature macro: MUL_ENABLE_EN (iterative shift-add multiplier, uop 01001).
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready     uop issue handshake from decode
//   uop, sel_p0, sel_p1     opcode, LHS and RHS register selects
//   sel_in                  destination register select
//   imm_en, imm             RHS = imm when imm_en is set
//   set_flags               allow the op to update flags
//   out_valid, result       one-cycle strobe with the completed uop's value
//   flags_out               flags register, bit order [Z, C, N, V]
//   pc_out                  current contents of reg[NREGS-1]
module execute_unit #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int SW    = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       uop,
  input  logic [SW-1:0]    sel_p0,
  input  logic [SW-1:0]    sel_p1,
  input  logic [SW-1:0]    sel_in,
  input  logic             imm_en,
  input  logic [WIDTH-1:0] imm,
  input  logic             set_flags,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags_out,
  output logic [WIDTH-1:0] pc_out
);

  localparam int SHW = $clog2(WIDTH) + 1;

  localparam logic [4:0] OP_MOV = 5'b00000;
  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_AND = 5'b00011;
  localparam logic [4:0] OP_ORR = 5'b00100;
  localparam logic [4:0] OP_EOR = 5'b00101;
  localparam logic [4:0] OP_LSL = 5'b00110;
  localparam logic [4:0] OP_LSR = 5'b00111;
  localparam logic [4:0] OP_CMP = 5'b01000;
`ifdef MUL_ENABLE_EN
  localparam logic [4:0] OP_MUL = 5'b01001;
  localparam int         CW     = $clog2(WIDTH);
`endif

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [3:0]       flags_q;
  logic [WIDTH-1:0] result_q;
  logic             out_valid_q;
  logic             in_ready_q;

  logic [WIDTH-1:0] lhs;
  logic [WIDTH-1:0] rhs;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;

  logic [WIDTH-1:0] res_d;
  logic [3:0]       flags_d;
  logic             wr_en;
  logic             fl_en;
  logic             c_d;
  logic             v_d;

  assign lhs   = regs_q[sel_p0];
  assign rhs   = imm_en ? imm : regs_q[sel_p1];
  assign shamt = rhs[SHW-1:0];
  assign add_w = {1'b0, lhs} + {1'b0, rhs};
  assign sub_w = {1'b0, lhs} - {1'b0, rhs};
  // One extra bit on the exit side of each shifter catches the last bit shifted
  // out; amounts beyond WIDTH push it off the end, leaving C=0 and result 0.
  assign shl_w = {1'b0, lhs} << shamt;
  assign shr_w = {lhs, 1'b0} >> shamt;

`ifdef MUL_ENABLE_EN
  typedef enum logic {IDLE, MUL_BUSY} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] mul_acc_q;
  logic [WIDTH-1:0] mul_mcand_q;
  logic [WIDTH-1:0] mul_mplier_q;
  logic [CW-1:0]    mul_cnt_q;
  logic [SW-1:0]    mul_dst_q;
  logic             mul_sf_q;
  logic [WIDTH-1:0] mul_acc_d;
  logic             mul_go;

  assign mul_acc_d = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : '0);
  assign mul_go    = (uop == OP_MUL);
`endif

  always_comb begin
    res_d = '0;
    wr_en = 1'b0;
    fl_en = 1'b0;
    c_d   = flags_q[2];
    v_d   = flags_q[0];
    unique case (uop)
      OP_MOV: begin res_d = rhs;       wr_en = 1'b1; fl_en = set_flags; end
      OP_AND: begin res_d = lhs & rhs; wr_en = 1'b1; fl_en = set_flags; end
      OP_ORR: begin res_d = lhs | rhs; wr_en = 1'b1; fl_en = set_flags; end
      OP_EOR: begin res_d = lhs ^ rhs; wr_en = 1'b1; fl_en = set_flags; end
      OP_ADD: begin
        res_d = add_w[WIDTH-1:0];
        wr_en = 1'b1;
        fl_en = set_flags;
        c_d   = add_w[WIDTH];
        v_d   = (lhs[WIDTH-1] == rhs[WIDTH-1]) && (add_w[WIDTH-1] != lhs[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        res_d = sub_w[WIDTH-1:0];
        wr_en = (uop == OP_SUB);
        fl_en = set_flags || (uop == OP_CMP);
        c_d   = ~sub_w[WIDTH];
        v_d   = (lhs[WIDTH-1] != rhs[WIDTH-1]) && (sub_w[WIDTH-1] != lhs[WIDTH-1]);
      end
      OP_LSL: begin
        res_d = shl_w[WIDTH-1:0];
        wr_en = 1'b1;
        fl_en = set_flags;
        if (shamt != '0) c_d = shl_w[WIDTH];
      end
      OP_LSR: begin
        res_d = shr_w[WIDTH:1];
        wr_en = 1'b1;
        fl_en = set_flags;
        if (shamt != '0) c_d = shr_w[0];
      end
      default: begin
        res_d = '0;
      end
    endcase
    flags_d = fl_en ? {(res_d == '0), c_d, res_d[WIDTH-1], v_d} : flags_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      flags_q     <= 4'b0000;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef MUL_ENABLE_EN
      state_q      <= IDLE;
      mul_acc_q    <= '0;
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
      mul_cnt_q    <= '0;
      mul_dst_q    <= '0;
      mul_sf_q     <= 1'b0;
`endif
    end else begin
      out_valid_q <= 1'b0;
`ifdef MUL_ENABLE_EN
      if (state_q == MUL_BUSY) begin
        mul_acc_q    <= mul_acc_d;
        mul_mcand_q  <= mul_mcand_q << 1;
        mul_mplier_q <= mul_mplier_q >> 1;
        mul_cnt_q    <= mul_cnt_q + 1'b1;
        if (mul_cnt_q == CW'(WIDTH - 1)) begin
          regs_q[mul_dst_q] <= mul_acc_d;
          result_q          <= mul_acc_d;
          if (mul_sf_q) begin
            flags_q[3] <= (mul_acc_d == '0);
            flags_q[1] <= mul_acc_d[WIDTH-1];
          end
          out_valid_q <= 1'b1;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      end else
`endif
      if (in_valid && in_ready_q) begin
`ifdef MUL_ENABLE_EN
        if (mul_go) begin
          state_q      <= MUL_BUSY;
          in_ready_q   <= 1'b0;
          mul_acc_q    <= '0;
          mul_mcand_q  <= lhs;
          mul_mplier_q <= rhs;
          mul_cnt_q    <= '0;
          mul_dst_q    <= sel_in;
          mul_sf_q     <= set_flags;
        end else
`endif
        begin
          if (wr_en) regs_q[sel_in] <= res_d;
          flags_q     <= flags_d;
          result_q    <= res_d;
          out_valid_q <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags_out = flags_q;
  assign pc_out    = regs_q[NREGS-1];

endmodule

// File: tb/tb_execute_unit.sv
// tb/tb_execute_unit.sv - directed self-checking bench for execute_unit
module tb_execute_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  uop;
  logic [3:0]  sel_p0, sel_p1, sel_in;
  logic        imm_en;
  logic [31:0] imm;
  logic        set_flags;
  logic        out_valid;
  logic [31:0] result;
  logic [3:0]  flags_out;
  logic [31:0] pc_out;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  execute_unit #(.WIDTH(32), .NREGS(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .uop(uop), .sel_p0(sel_p0), .sel_p1(sel_p1), .sel_in(sel_in),
    .imm_en(imm_en), .imm(imm), .set_flags(set_flags),
    .out_valid(out_valid), .result(result), .flags_out(flags_out), .pc_out(pc_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [4:0] u, input logic [3:0] p0, input logic [3:0] p1,
                       input logic [3:0] d, input logic ie, input logic [31:0] im,
                       input logic sf);
    in_valid  = 1'b1;
    uop       = u;
    sel_p0    = p0;
    sel_p1    = p1;
    sel_in    = d;
    imm_en    = ie;
    imm       = im;
    set_flags = sf;
    @(posedge clock); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; uop = '0; sel_p0 = '0; sel_p1 = '0; sel_in = '0;
    imm_en = 1'b0; imm = '0; set_flags = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {28'b0, flags_out}, 32'd0);
    check("rst_pc", pc_out, 32'd0);

    // back-to-back MOVs
    issue(5'b00000, 0, 0, 0, 1, 32'd2, 0);
    check("mov0_valid", {31'b0, out_valid}, 32'd1);
    check("mov0_result", result, 32'd2);
    issue(5'b00000, 0, 0, 1, 1, 32'd1, 0);
    check("mov1_valid", {31'b0, out_valid}, 32'd1);
    check("mov1_result", result, 32'd1);
    check("mov1_flags", {28'b0, flags_out}, 32'h0);
    idle();
    check("idle_valid", {31'b0, out_valid}, 32'd0);

    issue(5'b00010, 1, 0, 2, 0, 32'd0, 1);
    check("sub_result", result, 32'hFFFFFFFF);
    check("sub_flags", {28'b0, flags_out}, 32'h2);

    issue(5'b01000, 0, 0, 2, 1, 32'd2, 0);
    check("cmp_result", result, 32'd0);
    check("cmp_flags", {28'b0, flags_out}, 32'hC);
    issue(5'b00000, 0, 2, 8, 0, 32'd0, 0);
    check("cmp_r2_kept", result, 32'hFFFFFFFF);

    issue(5'b00000, 0, 0, 3, 1, 32'h7FFFFFFF, 0);
    issue(5'b00001, 3, 0, 4, 1, 32'd1, 1);
    check("add_result", result, 32'h80000000);
    check("add_flags", {28'b0, flags_out}, 32'h3);
    issue(5'b00000, 0, 4, 9, 0, 32'd0, 0);
    check("add_r4", result, 32'h80000000);

    // shifts: V stays 1 from the ADD
    issue(5'b00110, 1, 0, 10, 1, 32'd32, 1);
    check("lsl32_result", result, 32'd0);
    check("lsl32_flags", {28'b0, flags_out}, 32'hD);
    issue(5'b00000, 0, 0, 11, 1, 32'd3, 0);
    issue(5'b00111, 11, 0, 12, 1, 32'd1, 1);
    check("lsr1_result", result, 32'd1);
    check("lsr1_flags", {28'b0, flags_out}, 32'h5);
    issue(5'b00110, 11, 0, 12, 1, 32'd33, 1);
    check("lsl33_result", result, 32'd0);
    check("lsl33_flags", {28'b0, flags_out}, 32'h9);
    issue(5'b00110, 11, 0, 12, 1, 32'd0, 1);
    check("lsl0_result", result, 32'd3);
    check("lsl0_flags", {28'b0, flags_out}, 32'h1);
    issue(5'b00110, 11, 0, 12, 1, 32'd31, 1);
    check("lsl31_result", result, 32'h80000000);
    check("lsl31_flags", {28'b0, flags_out}, 32'h7);

    issue(5'b00000, 0, 0, 15, 1, 32'd40, 0);
    check("pc_write", pc_out, 32'd40);

    issue(5'b11111, 0, 0, 0, 1, 32'd9, 1);
    check("nop_valid", {31'b0, out_valid}, 32'd1);
    check("nop_result", result, 32'd0);
    check("nop_flags", {28'b0, flags_out}, 32'h7);
    issue(5'b00000, 0, 0, 13, 0, 32'd0, 0);
    check("nop_r0_kept", result, 32'd2);

    issue(5'b00001, 0, 0, 0, 1, 32'd5, 0);
    check("self_add", result, 32'd7);
    issue(5'b00000, 0, 0, 13, 0, 32'd0, 0);
    check("self_r0", result, 32'd7);
    check("self_flags", {28'b0, flags_out}, 32'h7);

`ifdef MUL_ENABLE_EN
    issue(5'b00000, 0, 0, 5, 1, 32'd7, 0);
    issue(5'b00000, 0, 0, 6, 1, 32'd6, 0);
    issue(5'b01001, 5, 6, 7, 0, 32'd0, 1);
    in_valid = 1'b0;
    check("mul_busy_rdy0", {31'b0, in_ready}, 32'd0);
    check("mul_busy_ov0", {31'b0, out_valid}, 32'd0);
    for (int i = 1; i < 32; i++) begin
      @(posedge clock); #1;
      check("mul_busy_rdy", {31'b0, in_ready}, 32'd0);
      check("mul_busy_ov", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clock); #1;
    check("mul_done_rdy", {31'b0, in_ready}, 32'd1);
    check("mul_done_ov", {31'b0, out_valid}, 32'd1);
    check("mul_result", result, 32'd42);
    check("mul_flags", {28'b0, flags_out}, 32'h5);
    idle();
    check("mul_ov_once", {31'b0, out_valid}, 32'd0);
    issue(5'b00000, 0, 7, 13, 0, 32'd0, 0);
    check("mul_r7", result, 32'd42);

    issue(5'b01001, 5, 6, 7, 0, 32'd0, 1);
    in_valid = 1'b0;
    repeat (9) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_rdy", {31'b0, in_ready}, 32'd1);
    check("abort_ov", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      check("abort_no_ov", {31'b0, out_valid}, 32'd0);
    end
    issue(5'b00000, 0, 7, 13, 0, 32'd0, 0);
    check("abort_r7", result, 32'd0);
`else
    issue(5'b01001, 0, 0, 1, 1, 32'd3, 1);
    check("mulnop_valid", {31'b0, out_valid}, 32'd1);
    check("mulnop_result", result, 32'd0);
    check("mulnop_flags", {28'b0, flags_out}, 32'h7);
    issue(5'b00000, 0, 1, 13, 0, 32'd0, 0);
    check("mulnop_r1", result, 32'd1);
`endif
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
